proc_controller: RTL and testbench
==================================

// Module: proc_controller
// PURPOSE
//  Multi-cycle control unit for the 16-bit datapath (register file, ALU, data RAM, write-back mux).
//  Holds PC and IR, fetches from instruction ROM and decodes opcodes. Sequences each instruction
//  through a Moore FSM that drives RAM, register-file, ALU and write-back mux select (RF_s: 1=RAM, 0=ALU).
// PARAMETERS
//  PC_W    7     PC width; instruction ROM depth = 2**PC_W
//  ALU_ADD 3'd1  ALU_s0 code for add (A+B)
//  ALU_SUB 3'd2  ALU_s0 code for subtract (A-B)
//  ALU_NOP 3'd0  ALU_s0 code driven in all non-arithmetic states
// PORTS
//  Clock      in   1     system clock, all state updates on rising edge
//  Reset      in   1     asynchronous, active-high reset
//  Instr      in   16    ROM data for address PC_Addr (combinational read)
//  PC_Addr    out  PC_W  program counter, ROM address
//  IR_Out     out  16    instruction register contents
//  D_Addr     out  8     data RAM address
//  D_Wr       out  1     data RAM write enable
//  RF_s       out  1     write-back mux select: 1=RAM read data, 0=ALU result
//  RF_W_en    out  1     register-file write enable
//  RF_W_addr  out  4     register-file write address
//  RF_Ra_addr out  4     register-file read port A address
//  RF_Rb_addr out  4     register-file read port B address
//  ALU_s0     out  3     ALU function select
//  Halted     out  1     high while FSM is in HALT
//  State      out  4     current state encoding (debug)
// BEHAVIOUR
//  Opcode IR[15:12]: NOOP 0000, STORE 0001, LOAD 0010, ADD 0011, SUB 0100, HALT 0101; others decode as NOOP.
//  Fields: LOAD D_Addr=IR[11:4], RF_W_addr=IR[3:0]. STORE RF_Ra_addr=IR[11:8], D_Addr=IR[7:0].
//    ADD/SUB RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0].
//  State codes: INIT=0 FETCH=1 DECODE=2 NOOP=3 LOAD_A=4 LOAD_B=5 STORE=6 ADD=7 SUB=8 HALT=9.
//  Reset (async, any time, mid-instruction included): State=INIT, PC=0, IR=0 immediately.
//    Outputs then: all enables 0, RF_s=0, ALU_s0=ALU_NOP, address outputs 0, Halted=0.
//  INIT -> FETCH unconditionally on first edge with Reset low.
//  FETCH: on exit edge IR<=Instr and PC<=PC+1 (mod 2**PC_W; all-ones wraps to 0). -> DECODE.
//  DECODE: no enables. Next state from IR[15:12]: NOOP/LOAD_A/STORE/ADD/SUB/HALT.
//  NOOP -> FETCH. No enables.
//  LOAD_A: D_Addr driven, RF_s=1, RF_W_en=0 (RAM sync read, data valid next cycle). -> LOAD_B.
//  LOAD_B: D_Addr held, RF_s=1, RF_W_en=1, RF_W_addr driven. -> FETCH.
//  STORE: D_Addr, RF_Ra_addr driven, D_Wr=1 for exactly one cycle. -> FETCH.
//  ADD/SUB: Ra/Rb/W addrs driven, ALU_s0=ALU_ADD/ALU_SUB, RF_s=0, RF_W_en=1 one cycle. -> FETCH.
//  HALT: Halted=1, no enables, PC/IR frozen; leaves only via Reset.
//  Latency: NOOP/STORE/ADD/SUB 3 cycles each (FETCH, DECODE, exec); LOAD 4 cycles.
//  Outputs are pure decode of State+IR (Moore); D_Wr and RF_W_en never high in the same cycle.
//  PC/IR change only on FETCH exit edge; address outputs not used by a state are driven 0.
// TESTING
//  Reset mid-LOAD_A with PC=5 -> State=0, PC_Addr=0, IR_Out=0, all enables 0 same cycle.
//  ROM[0]=16'h2_1B_3 (LOAD R3<-RAM[0x1B]): RF_s=1 cycles 3-4, D_Addr=8'h1B, RF_W_en=1 only cycle 4.
//  ROM[1]=16'h3_12_4 (ADD R4=R1+R2): exec cycle ALU_s0=1, Ra=1, Rb=2, W=4, RF_s=0, RF_W_en=1.
//  ROM[2]=16'h1_4_20 (STORE RAM[0x20]<-R4): D_Wr=1 one cycle, RF_Ra_addr=4, RF_W_en=0.
//  ROM[3]=16'hF000 (illegal) -> NOOP path, 3 cycles, no enables; ROM[4]=16'h5000 -> Halted=1, PC=5 held 20 cycles.
//  PC_W=2, four NOOPs -> PC_Addr sequence 0,1,2,3,0 (wrap), one increment per 3 cycles.

Source files
------------

// File: rtl/proc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : proc_controller
//  Purpose  : Multi-cycle control unit for a 16-bit datapath. Holds the
//             program counter and instruction register, fetches from an
//             instruction ROM, decodes the opcode, and sequences each
//             instruction through a Moore FSM that drives the data RAM,
//             register file, ALU and write-back mux select.
//  Ports    : Clock, Reset (async, active high)
//             Instr      - ROM data at PC_Addr (combinational read)
//             PC_Addr    - program counter / ROM address
//             IR_Out     - instruction register
//             D_Addr, D_Wr                   - data RAM address / write enable
//             RF_s                           - write-back select (1=RAM, 0=ALU)
//             RF_W_en, RF_W_addr             - register-file write port
//             RF_Ra_addr, RF_Rb_addr         - register-file read ports
//             ALU_s0                         - ALU function select
//             Halted, State                  - status / debug
//  Revision : 1.0 - initial release
// ============================================================================
module proc_controller #(
    parameter int          PC_W    = 7,
    parameter logic [2:0]  ALU_ADD = 3'd1,
    parameter logic [2:0]  ALU_SUB = 3'd2,
    parameter logic [2:0]  ALU_NOP = 3'd0
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [15:0]     Instr,
    output logic [PC_W-1:0] PC_Addr,
    output logic [15:0]     IR_Out,
    output logic [7:0]      D_Addr,
    output logic            D_Wr,
    output logic            RF_s,
    output logic            RF_W_en,
    output logic [3:0]      RF_W_addr,
    output logic [3:0]      RF_Ra_addr,
    output logic [3:0]      RF_Rb_addr,
    output logic [2:0]      ALU_s0,
    output logic            Halted,
    output logic [3:0]      State
);

    localparam logic [3:0] c_OP_NOOP  = 4'b0000;
    localparam logic [3:0] c_OP_STORE = 4'b0001;
    localparam logic [3:0] c_OP_LOAD  = 4'b0010;
    localparam logic [3:0] c_OP_ADD   = 4'b0011;
    localparam logic [3:0] c_OP_SUB   = 4'b0100;
    localparam logic [3:0] c_OP_HALT  = 4'b0101;

    // Encodings are visible on the State debug port, so they are pinned.
    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic [3:0]      w_op;

    assign w_op = r_ir[15:12];

    // ------------------------------------------------------------------
    // State, PC and IR registers. PC and IR only move on the FETCH exit
    // edge; the PC increment wraps naturally at PC_W bits.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_INIT;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_FETCH) begin
                r_ir <= Instr;
                r_pc <= r_pc + PC_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT:   w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    c_OP_STORE: w_next_state = S_STORE;
                    c_OP_LOAD:  w_next_state = S_LOAD_A;
                    c_OP_ADD:   w_next_state = S_ADD;
                    c_OP_SUB:   w_next_state = S_SUB;
                    c_OP_HALT:  w_next_state = S_HALT;
                    c_OP_NOOP:  w_next_state = S_NOOP;
                    default:    w_next_state = S_NOOP;   // illegal opcodes
                endcase
            end
            S_LOAD_A: w_next_state = S_LOAD_B;
            S_NOOP,
            S_LOAD_B,
            S_STORE,
            S_ADD,
            S_SUB:    w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_INIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs: decoded from State and IR only. Address fields not
    // used by the current state are forced to zero.
    // ------------------------------------------------------------------
    always_comb begin
        D_Addr     = 8'd0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_en    = 1'b0;
        RF_W_addr  = 4'd0;
        RF_Ra_addr = 4'd0;
        RF_Rb_addr = 4'd0;
        ALU_s0     = ALU_NOP;
        Halted     = 1'b0;
        case (r_state)
            // RAM read is synchronous: the address goes out in LOAD_A and is
            // held in LOAD_B, when the read data is valid for write-back.
            S_LOAD_A: begin
                D_Addr = r_ir[11:4];
                RF_s   = 1'b1;
            end
            S_LOAD_B: begin
                D_Addr    = r_ir[11:4];
                RF_s      = 1'b1;
                RF_W_en   = 1'b1;
                RF_W_addr = r_ir[3:0];
            end
            S_STORE: begin
                D_Addr     = r_ir[7:0];
                RF_Ra_addr = r_ir[11:8];
                D_Wr       = 1'b1;
            end
            S_ADD: begin
                RF_Ra_addr = r_ir[11:8];
                RF_Rb_addr = r_ir[7:4];
                RF_W_addr  = r_ir[3:0];
                ALU_s0     = ALU_ADD;
                RF_W_en    = 1'b1;
            end
            S_SUB: begin
                RF_Ra_addr = r_ir[11:8];
                RF_Rb_addr = r_ir[7:4];
                RF_W_addr  = r_ir[3:0];
                ALU_s0     = ALU_SUB;
                RF_W_en    = 1'b1;
            end
            S_HALT:  Halted = 1'b1;
            default: ;
        endcase
    end

    assign PC_Addr = r_pc;
    assign IR_Out  = r_ir;
    assign State   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_proc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_proc_controller
//  Purpose  : Self-checking bench for proc_controller. An instruction-level
//             reference model expands each program word into its expected
//             per-cycle control pattern and checks it against the DUT.
//             A second PC_W=2 instance checks program-counter wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_proc_controller;

    logic        Clock;
    logic        Reset;
    logic [15:0] Instr;
    logic [6:0]  PC_Addr;
    logic [15:0] IR_Out;
    logic [7:0]  D_Addr;
    logic        D_Wr, RF_s, RF_W_en, Halted;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
    logic [2:0]  ALU_s0;

    logic        Reset2;
    logic [15:0] Instr2;
    logic [1:0]  PC_Addr2;
    logic [15:0] IR_Out2;
    logic [7:0]  D_Addr2;
    logic        D_Wr2, RF_s2, RF_W_en2, Halted2;
    logic [3:0]  RF_W_addr2, RF_Ra_addr2, RF_Rb_addr2, State2;
    logic [2:0]  ALU_s02;

    logic [15:0] rom [0:127];
    int          total = 0;
    int          bad   = 0;
    int          m_pc;
    logic [15:0] m_ir;

    assign Instr  = rom[PC_Addr];
    assign Instr2 = 16'h0000;

    proc_controller #(.PC_W(7)) dut (
        .Clock(Clock), .Reset(Reset), .Instr(Instr), .PC_Addr(PC_Addr),
        .IR_Out(IR_Out), .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s),
        .RF_W_en(RF_W_en), .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr),
        .RF_Rb_addr(RF_Rb_addr), .ALU_s0(ALU_s0), .Halted(Halted), .State(State)
    );

    proc_controller #(.PC_W(2)) dut2 (
        .Clock(Clock), .Reset(Reset2), .Instr(Instr2), .PC_Addr(PC_Addr2),
        .IR_Out(IR_Out2), .D_Addr(D_Addr2), .D_Wr(D_Wr2), .RF_s(RF_s2),
        .RF_W_en(RF_W_en2), .RF_W_addr(RF_W_addr2), .RF_Ra_addr(RF_Ra_addr2),
        .RF_Rb_addr(RF_Rb_addr2), .ALU_s0(ALU_s02), .Halted(Halted2), .State(State2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Compare every DUT output against one expected control pattern.
    task automatic chk_cycle(input string tag, input int st, input int pc, input logic [15:0] ir,
                             input logic [7:0] daddr, input bit dwr, input bit rfs, input bit wen,
                             input logic [3:0] waddr, input logic [3:0] ra, input logic [3:0] rb,
                             input logic [2:0] alu, input bit hlt);
        chk({tag, ".state"},  32'(State),      32'(st));
        chk({tag, ".pc"},     32'(PC_Addr),    32'(pc));
        chk({tag, ".ir"},     32'(IR_Out),     32'(ir));
        chk({tag, ".daddr"},  32'(D_Addr),     32'(daddr));
        chk({tag, ".dwr"},    32'(D_Wr),       32'(dwr));
        chk({tag, ".rfs"},    32'(RF_s),       32'(rfs));
        chk({tag, ".wen"},    32'(RF_W_en),    32'(wen));
        chk({tag, ".waddr"},  32'(RF_W_addr),  32'(waddr));
        chk({tag, ".ra"},     32'(RF_Ra_addr), 32'(ra));
        chk({tag, ".rb"},     32'(RF_Rb_addr), 32'(rb));
        chk({tag, ".alu"},    32'(ALU_s0),     32'(alu));
        chk({tag, ".halted"}, 32'(Halted),     32'(hlt));
        chk({tag, ".excl"},   32'(D_Wr & RF_W_en), 32'd0);
    endtask

    // Hold reset for a cycle, check the cleared outputs, release, and step
    // into the first FETCH.
    task automatic do_reset(input string tag);
        Reset = 1'b1;
        tick();
        chk_cycle({tag, "/rst"}, 0, 0, 16'h0, 8'h0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'd0, 0);
        m_pc  = 0;
        m_ir  = 16'h0;
        Reset = 1'b0;
        tick();
    endtask

    // Instruction-level model: starts in FETCH, checks every cycle of one
    // instruction and leaves the bench at the next FETCH (or in HALT).
    // abort_load asserts reset during LOAD_A instead of completing the load.
    task automatic run_instr(input string tag, input bit abort_load, output bit halted);
        logic [3:0] op;
        halted = 0;
        chk_cycle({tag, "/fetch"}, 1, m_pc, m_ir, 8'h0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'd0, 0);
        tick();
        m_ir = rom[m_pc];
        m_pc = (m_pc + 1) % 128;
        chk_cycle({tag, "/decode"}, 2, m_pc, m_ir, 8'h0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'd0, 0);
        tick();
        op = m_ir[15:12];
        case (op)
            4'h2: begin
                chk_cycle({tag, "/load_a"}, 4, m_pc, m_ir, m_ir[11:4], 0, 1, 0,
                          4'h0, 4'h0, 4'h0, 3'd0, 0);
                if (abort_load) begin
                    Reset = 1'b1;
                    #1;
                    chk_cycle({tag, "/async_rst"}, 0, 0, 16'h0, 8'h0, 0, 0, 0,
                              4'h0, 4'h0, 4'h0, 3'd0, 0);
                    return;
                end
                tick();
                chk_cycle({tag, "/load_b"}, 5, m_pc, m_ir, m_ir[11:4], 0, 1, 1,
                          m_ir[3:0], 4'h0, 4'h0, 3'd0, 0);
                tick();
            end
            4'h1: begin
                chk_cycle({tag, "/store"}, 6, m_pc, m_ir, m_ir[7:0], 1, 0, 0,
                          4'h0, m_ir[11:8], 4'h0, 3'd0, 0);
                tick();
            end
            4'h3: begin
                chk_cycle({tag, "/add"}, 7, m_pc, m_ir, 8'h0, 0, 0, 1,
                          m_ir[3:0], m_ir[11:8], m_ir[7:4], 3'd1, 0);
                tick();
            end
            4'h4: begin
                chk_cycle({tag, "/sub"}, 8, m_pc, m_ir, 8'h0, 0, 0, 1,
                          m_ir[3:0], m_ir[11:8], m_ir[7:4], 3'd2, 0);
                tick();
            end
            4'h5: begin
                chk_cycle({tag, "/halt"}, 9, m_pc, m_ir, 8'h0, 0, 0, 0,
                          4'h0, 4'h0, 4'h0, 3'd0, 1);
                halted = 1;
            end
            default: begin
                chk_cycle({tag, "/noop"}, 3, m_pc, m_ir, 8'h0, 0, 0, 0,
                          4'h0, 4'h0, 4'h0, 3'd0, 0);
                tick();
            end
        endcase
    endtask

    initial begin
        bit h;
        int halt_at;
        logic [3:0] op;
        Reset  = 1'b1;
        Reset2 = 1'b1;
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;

        // Directed program: LOAD, ADD, STORE, illegal, HALT.
        rom[0] = 16'h21B3;
        rom[1] = 16'h3124;
        rom[2] = 16'h1420;
        rom[3] = 16'hF000;
        rom[4] = 16'h5000;
        do_reset("dir");
        for (int i = 0; i < 5; i++) begin
            run_instr($sformatf("dir%0d", i), 0, h);
            if (h) break;
        end
        chk("dir.reached_halt", 32'(h), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_cycle($sformatf("dir/hold%0d", i), 9, 5, 16'h5000, 8'h0, 0, 0, 0,
                      4'h0, 4'h0, 4'h0, 3'd0, 1);
        end

        // Asynchronous reset in the middle of LOAD_A with PC=5.
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[4] = 16'h2ABC;
        do_reset("abort");
        for (int i = 0; i < 4; i++) run_instr($sformatf("abort%0d", i), 0, h);
        run_instr("abort_ld", 1, h);
        tick();
        chk("abort.still_init", 32'(State), 32'd0);

        // Random programs with no HALT: exercise every opcode and PC wrap.
        for (int i = 0; i < 128; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'h5) op = 4'h3;
            rom[i] = {op, 12'($urandom)};
        end
        do_reset("rnd");
        for (int i = 0; i < 140; i++) run_instr($sformatf("rnd%0d", i), 0, h);

        // Random program terminated by a HALT at a random address.
        halt_at = $urandom_range(3, 20);
        for (int i = 0; i < 128; i++) begin
            op = 4'($urandom_range(0, 4));
            rom[i] = {op, 12'($urandom)};
        end
        rom[halt_at] = {4'h5, 12'($urandom)};
        do_reset("rh");
        h = 0;
        for (int i = 0; i <= halt_at && !h; i++) run_instr($sformatf("rh%0d", i), 0, h);
        chk("rh.reached_halt", 32'(h), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_cycle($sformatf("rh/hold%0d", i), 9, (halt_at + 1) % 128, rom[halt_at],
                      8'h0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'd0, 1);
        end

        // PC_W=2 instance running NOOPs: fetch PCs 0,1,2,3,0.
        tick();
        chk("w2.rst_pc", 32'(PC_Addr2), 32'd0);
        Reset2 = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("w2.state%0d", k), 32'(State2), 32'd1);
            chk($sformatf("w2.pc%0d", k), 32'(PC_Addr2), 32'(k % 4));
            chk($sformatf("w2.quiet%0d", k),
                32'({D_Wr2, RF_W_en2, RF_s2, Halted2, ALU_s02, D_Addr2, IR_Out2,
                     RF_W_addr2, RF_Ra_addr2, RF_Rb_addr2}), 32'd0);
            tick();
            tick();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
